serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
Downstream stage of the serial transceiver. It consumes the WIDTH-bit-per-beat MSB-first serial stream and reassembles 32-bit words. Each completed word is presented on a valid/ack handshake to the consuming logic. Framing, overrun and restart errors are flagged through sticky status bits. All logic runs in a single clock domain.

Parameters:
WIDTH, 1, beat width in bits. Legal values: 1, 2, 4, 8, 16, 32 (must divide 32). Any other value is an elaboration error.

Ports:
Clk  input  1  system clock; all logic on the rising edge
Reset  input  1  synchronous, active-high reset
Din  input  WIDTH  serial beat; MSB-first chunk of the word
DinValid  input  1  Din is valid this cycle
Sof  input  1  start of frame; qualified by DinValid; marks the first beat of a word
RxAck  input  1  consumer accepts DataOut
ErrClr  input  1  clears the sticky error flags
DataOut  output  32  assembled word; stable while RxValid=1
RxValid  output  1  word available; held until acknowledged
RxBusy  output  1  a frame is in progress (state SHIFT)
Overrun  output  1  sticky: a beat was dropped because the held word was not yet acknowledged
FrameErr  output  1  sticky: Sof arrived mid-frame

Behaviour:
- Constants: BEATS = 32/WIDTH. The beat counter is clog2(BEATS)+1 bits wide. Shift operation: sh <= {sh[31-WIDTH:0], Din}.
- Reset (synchronous, active-high; overrides every other input):
  - State goes to IDLE.
  - DataOut=0, RxValid=0, RxBusy=0, Overrun=0, FrameErr=0.
  - The shift register and counter are cleared.
- State IDLE:
  - DinValid & Sof: shift in the first beat and set cnt=1. If BEATS==1, go to HOLD; otherwise go to SHIFT.
  - DinValid without Sof: the beat is ignored and no flag is set.
- State SHIFT:
  - RxBusy=1.
  - DinValid=0: no change. Gaps of any length are allowed.
  - DinValid & !Sof: shift in the beat and increment cnt. When this is beat BEATS, load DataOut with the shifted value, set RxValid=1 and go to HOLD.
  - DinValid & Sof: set FrameErr=1. The partial word is discarded. This beat restarts the frame with cnt=1 (becomes beat 1).
- State HOLD:
  - RxValid=1 and DataOut is frozen.
  - RxAck: RxValid=0 on the next cycle and the state returns to IDLE.
  - RxAck together with DinValid & Sof in the same cycle: the ack is taken and the new frame starts (beat 1, go to SHIFT). No overrun.
  - DinValid without RxAck: the beat is dropped and Overrun=1.
- Latency: RxValid rises on the first edge after the final beat is sampled, so the word is visible in the cycle following the last DinValid.
- Error flags: ErrClr clears Overrun and FrameErr on the next edge. If ErrClr coincides with a new error event, the set wins.
- RxAck while RxValid=0: ignored.
- Reset mid-frame: the partial word is lost and no flag is set.

Optional Feature:
SERIAL_RX_PARITY_EN
- Defined:
  - Each frame carries one extra beat after the BEATS data beats. Din[0] of that beat is even parity over the 32-bit word.
  - RxValid asserts after the parity beat. RxBusy stays high through it.
  - Adds output ParityErr (1 bit, sticky). It is set when the XOR of the word with the parity bit is 1. The word is still delivered.
  - ParityErr is cleared by Reset or ErrClr.
  - Sof on the parity beat is treated as a FrameErr restart.
- Undefined: there is no parity beat, no ParityErr port, and behaviour is exactly as above.

Decomposition:
- Package serial_pkg holds:
  - WORD_W=32.
  - The state enum (IDLE, SHIFT, HOLD).
  - The beats(WIDTH) constant function.
  - The legal-WIDTH check.
- The transmitter shares the same package.
- One sub-module, serial_rx_shifter: shift register plus beat counter. Its interface is load_first, shift, count_out and word_out. The FSM, handshake and flags stay in the top level.

Test Plan:
- WIDTH=4; beats D,E,A,D,B,E,E,F on consecutive cycles with Sof on the first -> DataOut=0xDEADBEEF and RxValid=1 one cycle after beat 8. RxAck then drops RxValid the next cycle.
- WIDTH=4; same word with 3-cycle DinValid gaps between beats -> identical result, with RxBusy=1 throughout the frame.
- WIDTH=8; beats 0x12,0x34, then Sof with 0xAA,0xBB,0xCC,0xDD -> FrameErr=1 and DataOut=0xAABBCCDD. ErrClr then clears FrameErr.
- WIDTH=8; word 0x01020304 held without RxAck, then a new Sof beat arrives -> Overrun=1 and DataOut still 0x01020304. A second frame started in the same cycle as RxAck is accepted without error.
- WIDTH=2; Reset asserted after beat 7 of 16, then a full frame carrying 0xFFFF0000 -> all outputs are 0 after reset and the clean frame delivers 0xFFFF0000.
- SERIAL_RX_PARITY_EN, WIDTH=1; word 0x00000001 with parity 1 -> ParityErr=0. Same word with parity 0 -> ParityErr=1 and the word is still delivered.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transceiver: word width, FSM states,
// beat-count helper and the legal beat-width check.
package serial_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    function automatic int beats(input int width);
        return WORD_W / width;
    endfunction

    function automatic bit width_legal(input int width);
        return (width == 1) || (width == 2) || (width == 4) ||
               (width == 8) || (width == 16) || (width == 32);
    endfunction

endpackage

// File: rtl/serial_rx_shifter.sv
// Receive shift register and beat counter: load_first restarts a word with
// the current beat, shift appends the beat MSB-first.
module serial_rx_shifter
    import serial_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int CNT_W = $clog2(beats(WIDTH)) + 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Din,
    input  logic              load_first,
    input  logic              shift,
    output logic [CNT_W-1:0]  count_out,
    output logic [WORD_W-1:0] word_out
);

    logic [WORD_W-1:0] shifted;

    // A full-word beat replaces the register outright.
    if (WIDTH == WORD_W) begin : g_full
        assign shifted = Din;
    end else begin : g_part
        assign shifted = {word_out[WORD_W-1-WIDTH:0], Din};
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            word_out  <= '0;
            count_out <= '0;
        end else if (load_first) begin
            word_out  <= WORD_W'(Din);
            count_out <= CNT_W'(1);
        end else if (shift) begin
            word_out  <= shifted;
            count_out <= count_out + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Reassembles WIDTH-bit MSB-first beats into 32-bit words on a valid/ack
// handshake with sticky error flags. SERIAL_RX_PARITY_EN adds a parity beat.
//
// state | meaning
// IDLE  | waiting for a Sof beat
// SHIFT | frame in progress, collecting beats (and parity beat if enabled)
// HOLD  | word presented on DataOut until RxAck
module serial_word_receiver
    import serial_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [WIDTH-1:0]  Din,
    input  logic              DinValid,
    input  logic              Sof,
    input  logic              RxAck,
    input  logic              ErrClr,
    output logic [WORD_W-1:0] DataOut,
    output logic              RxValid,
    output logic              RxBusy,
    output logic              Overrun,
    output logic              FrameErr
`ifdef SERIAL_RX_PARITY_EN
    ,
    output logic              ParityErr
`endif
);

    localparam int BEATS = beats(WIDTH);
    localparam int CNT_W = $clog2(BEATS) + 1;
`ifdef SERIAL_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam state_t FIRST_NEXT = (BEATS == 1 && !PAR_EN) ? HOLD : SHIFT;

    if (!width_legal(WIDTH)) begin : g_bad_width
        $error("serial_word_receiver: WIDTH must divide 32 (1,2,4,8,16,32)");
    end

    state_t            state_q, state_d;
    logic              load_first, shift;
    logic              ovr_set, fe_set;
    logic [CNT_W-1:0]  count_out;
    logic [WORD_W-1:0] word_out;
`ifdef SERIAL_RX_PARITY_EN
    logic              pe_set;
`endif

    serial_rx_shifter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_shifter (
        .Clk        (Clk),
        .Reset      (Reset),
        .Din        (Din),
        .load_first (load_first),
        .shift      (shift),
        .count_out  (count_out),
        .word_out   (word_out)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        load_first = 1'b0;
        shift      = 1'b0;
        ovr_set    = 1'b0;
        fe_set     = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
        pe_set     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (DinValid && Sof) begin
                    load_first = 1'b1;
                    state_d    = FIRST_NEXT;
                end
            end
            SHIFT: begin
                if (DinValid) begin
                    if (Sof) begin
                        fe_set     = 1'b1;
                        load_first = 1'b1;
                        state_d    = FIRST_NEXT;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    else if (count_out == CNT_W'(BEATS)) begin
                        pe_set  = ^{word_out, Din[0]};
                        state_d = HOLD;
                    end
`endif
                    else begin
                        shift = 1'b1;
                        if (!PAR_EN && count_out == CNT_W'(BEATS - 1))
                            state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (RxAck) begin
                    if (DinValid && Sof) begin
                        load_first = 1'b1;
                        state_d    = FIRST_NEXT;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (DinValid) begin
                    ovr_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Flags: a new error event outranks a simultaneous clear.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Overrun  <= 1'b0;
            FrameErr <= 1'b0;
        end else begin
            if (ovr_set)     Overrun <= 1'b1;
            else if (ErrClr) Overrun <= 1'b0;
            if (fe_set)      FrameErr <= 1'b1;
            else if (ErrClr) FrameErr <= 1'b0;
        end
    end

`ifdef SERIAL_RX_PARITY_EN
    always_ff @(posedge Clk) begin
        if (Reset)       ParityErr <= 1'b0;
        else if (pe_set) ParityErr <= 1'b1;
        else if (ErrClr) ParityErr <= 1'b0;
    end
`endif

    assign DataOut = word_out;
    assign RxValid = (state_q == HOLD);
    assign RxBusy  = (state_q == SHIFT);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Self-checking bench for serial_word_receiver: instances at WIDTH 4, 8, 2
// (plus WIDTH 1 when SERIAL_RX_PARITY_EN is defined) with a word scoreboard.
`timescale 1ns/1ps
module tb_serial_word_receiver;

`ifdef SERIAL_RX_PARITY_EN
    localparam int NDUT = 4;
    localparam bit PAR  = 1'b1;
`else
    localparam int NDUT = 3;
    localparam bit PAR  = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Sof = 1'b0;
    logic        ErrClr = 1'b0;
    logic [7:0]  Din = '0;
    logic        dv   [NDUT];
    logic        ack  [NDUT];
    logic [31:0] dout [NDUT];
    logic        rv   [NDUT];
    logic        busy [NDUT];
    logic        ovr  [NDUT];
    logic        fe   [NDUT];
`ifdef SERIAL_RX_PARITY_EN
    logic        pe   [NDUT];
`endif

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    always #5 Clk = ~Clk;

    serial_word_receiver #(.WIDTH(4)) u_w4 (
        .Clk(Clk), .Reset(Reset), .Din(Din[3:0]), .DinValid(dv[0]), .Sof(Sof),
        .RxAck(ack[0]), .ErrClr(ErrClr), .DataOut(dout[0]), .RxValid(rv[0]),
        .RxBusy(busy[0]), .Overrun(ovr[0]), .FrameErr(fe[0])
`ifdef SERIAL_RX_PARITY_EN
        , .ParityErr(pe[0])
`endif
    );

    serial_word_receiver #(.WIDTH(8)) u_w8 (
        .Clk(Clk), .Reset(Reset), .Din(Din[7:0]), .DinValid(dv[1]), .Sof(Sof),
        .RxAck(ack[1]), .ErrClr(ErrClr), .DataOut(dout[1]), .RxValid(rv[1]),
        .RxBusy(busy[1]), .Overrun(ovr[1]), .FrameErr(fe[1])
`ifdef SERIAL_RX_PARITY_EN
        , .ParityErr(pe[1])
`endif
    );

    serial_word_receiver #(.WIDTH(2)) u_w2 (
        .Clk(Clk), .Reset(Reset), .Din(Din[1:0]), .DinValid(dv[2]), .Sof(Sof),
        .RxAck(ack[2]), .ErrClr(ErrClr), .DataOut(dout[2]), .RxValid(rv[2]),
        .RxBusy(busy[2]), .Overrun(ovr[2]), .FrameErr(fe[2])
`ifdef SERIAL_RX_PARITY_EN
        , .ParityErr(pe[2])
`endif
    );

`ifdef SERIAL_RX_PARITY_EN
    serial_word_receiver #(.WIDTH(1)) u_w1 (
        .Clk(Clk), .Reset(Reset), .Din(Din[0:0]), .DinValid(dv[3]), .Sof(Sof),
        .RxAck(ack[3]), .ErrClr(ErrClr), .DataOut(dout[3]), .RxValid(rv[3]),
        .RxBusy(busy[3]), .Overrun(ovr[3]), .FrameErr(fe[3]), .ParityErr(pe[3])
    );
`endif

    function automatic int wid(input int k);
        case (k)
            0: return 4;
            1: return 8;
            2: return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic [7:0] chunk(input logic [31:0] word, input int k, input int b);
        int w;
        logic [31:0] s;
        logic [7:0]  m;
        w = wid(k);
        s = word >> (32 - (b + 1) * w);
        m = 8'((1 << w) - 1);
        return s[7:0] & m;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send_beat(input int k, input logic [7:0] val, input logic sof,
                             input logic with_ack);
        Din = val; Sof = sof; dv[k] = 1'b1; ack[k] = with_ack;
        tick();
        dv[k] = 1'b0; Sof = 1'b0; ack[k] = 1'b0; Din = '0;
    endtask

    task automatic send_word(input int k, input logic [31:0] word,
                             input logic ack_first, input logic bad_par);
        int n;
        n = 32 / wid(k);
        exp_q.push_back(word);
        for (int b = 0; b < n; b++)
            send_beat(k, chunk(word, k, b), b == 0, ack_first && b == 0);
        if (PAR) send_beat(k, {7'b0, (^word) ^ bad_par}, 1'b0, 1'b0);
    endtask

    task automatic expect_word(input int k, input string name);
        int n;
        logic [31:0] exp;
        n = 0;
        while (rv[k] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (rv[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s valid_timeout: RxValid=%b required 1", name, rv[k]);
        end else if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard_empty: got %h required none", name, dout[k]);
        end else begin
            exp = exp_q.pop_front();
            checks++;
            if (dout[k] !== exp) begin
                errors++;
                $display("FAIL %s data: got %h required %h", name, dout[k], exp);
            end
        end
        ack[k] = 1'b1;
        tick();
        ack[k] = 1'b0;
        checks++;
        if (rv[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s valid_after_ack: RxValid=%b required 0", name, rv[k]);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < NDUT; k++) begin
            checks += 5;
            if (dout[k] !== 32'h0) begin errors++; $display("FAIL reset_dout%0d: got %h required 0", k, dout[k]); end
            if (rv[k] !== 1'b0) begin errors++; $display("FAIL reset_valid%0d: got %b required 0", k, rv[k]); end
            if (busy[k] !== 1'b0) begin errors++; $display("FAIL reset_busy%0d: got %b required 0", k, busy[k]); end
            if (ovr[k] !== 1'b0) begin errors++; $display("FAIL reset_ovr%0d: got %b required 0", k, ovr[k]); end
            if (fe[k] !== 1'b0) begin errors++; $display("FAIL reset_fe%0d: got %b required 0", k, fe[k]); end
`ifdef SERIAL_RX_PARITY_EN
            checks++;
            if (pe[k] !== 1'b0) begin errors++; $display("FAIL reset_pe%0d: got %b required 0", k, pe[k]); end
`endif
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        send_word(0, 32'hDEADBEEF, 1'b0, 1'b0);
        checks += 2;
        if (rv[0] !== 1'b1) begin errors++; $display("FAIL b2b_latency: RxValid=%b required 1", rv[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL b2b_busy: RxBusy=%b required 0", busy[0]); end
        expect_word(0, "b2b");
    endtask

    task automatic test_gaps();
        exp_q.push_back(32'hDEADBEEF);
        for (int b = 0; b < 8; b++) begin
            send_beat(0, chunk(32'hDEADBEEF, 0, b), b == 0, 1'b0);
            if (b < 7 || PAR) begin
                repeat (3) tick();
                checks++;
                if (busy[0] !== 1'b1 || rv[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL gaps_busy beat%0d: busy=%b valid=%b required 1/0", b, busy[0], rv[0]);
                end
            end
        end
        if (PAR) send_beat(0, {7'b0, ^32'hDEADBEEF}, 1'b0, 1'b0);
        expect_word(0, "gaps");
    endtask

    task automatic test_idle_ignore();
        send_beat(1, 8'h55, 1'b0, 1'b0);
        ack[1] = 1'b1;
        tick();
        ack[1] = 1'b0;
        checks += 3;
        if (busy[1] !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy[1]); end
        if (rv[1] !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b required 0", rv[1]); end
        if (fe[1] !== 1'b0 || ovr[1] !== 1'b0) begin
            errors++; $display("FAIL idle_flags: fe=%b ovr=%b required 0/0", fe[1], ovr[1]);
        end
    endtask

    task automatic test_frame_err();
        send_beat(1, 8'h12, 1'b1, 1'b0);
        send_beat(1, 8'h34, 1'b0, 1'b0);
        checks++;
        if (fe[1] !== 1'b0) begin errors++; $display("FAIL ferr_early: got %b required 0", fe[1]); end
        send_word(1, 32'hAABBCCDD, 1'b0, 1'b0);
        checks++;
        if (fe[1] !== 1'b1) begin errors++; $display("FAIL ferr_set: got %b required 1", fe[1]); end
        expect_word(1, "ferr");
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        checks++;
        if (fe[1] !== 1'b0) begin errors++; $display("FAIL ferr_clear: got %b required 0", fe[1]); end
    endtask

    task automatic test_overrun();
        logic [31:0] exp;
        send_word(1, 32'h01020304, 1'b0, 1'b0);
        ErrClr = 1'b1;
        send_beat(1, 8'hAA, 1'b1, 1'b0);
        ErrClr = 1'b0;
        exp = exp_q.pop_front();
        checks += 3;
        if (ovr[1] !== 1'b1) begin errors++; $display("FAIL ovr_set_wins: got %b required 1", ovr[1]); end
        if (dout[1] !== exp) begin errors++; $display("FAIL ovr_hold_data: got %h required %h", dout[1], exp); end
        if (rv[1] !== 1'b1) begin errors++; $display("FAIL ovr_hold_valid: got %b required 1", rv[1]); end
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        checks++;
        if (ovr[1] !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b required 0", ovr[1]); end
        send_word(1, 32'h05060708, 1'b1, 1'b0);
        checks++;
        if (ovr[1] !== 1'b0 || fe[1] !== 1'b0) begin
            errors++; $display("FAIL ack_sof_flags: ovr=%b fe=%b required 0/0", ovr[1], fe[1]);
        end
        expect_word(1, "ack_sof");
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 7; b++) send_beat(2, 8'(b), b == 0, 1'b0);
        checks++;
        if (busy[2] !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b required 1", busy[2]); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        checks++;
        if (dout[2] !== 32'h0 || rv[2] !== 1'b0 || busy[2] !== 1'b0 || ovr[2] !== 1'b0 || fe[2] !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: dout=%h v=%b b=%b o=%b f=%b required all 0",
                     dout[2], rv[2], busy[2], ovr[2], fe[2]);
        end
        send_word(2, 32'hFFFF0000, 1'b0, 1'b0);
        expect_word(2, "after_reset");
    endtask

`ifdef SERIAL_RX_PARITY_EN
    task automatic test_parity();
        send_word(3, 32'h00000001, 1'b0, 1'b0);
        checks++;
        if (pe[3] !== 1'b0) begin errors++; $display("FAIL parity_good: got %b required 0", pe[3]); end
        expect_word(3, "parity_good");
        send_word(3, 32'h00000001, 1'b0, 1'b1);
        checks++;
        if (pe[3] !== 1'b1) begin errors++; $display("FAIL parity_bad: got %b required 1", pe[3]); end
        expect_word(3, "parity_bad");
        ErrClr = 1'b1;
        tick();
        ErrClr = 1'b0;
        checks++;
        if (pe[3] !== 1'b0) begin errors++; $display("FAIL parity_clear: got %b required 0", pe[3]); end
    endtask
`endif

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            dv[k]  = 1'b0;
            ack[k] = 1'b0;
        end
        test_reset();
        test_back_to_back();
        test_gaps();
        test_idle_ignore();
        test_frame_err();
        test_overrun();
        test_reset_mid();
`ifdef SERIAL_RX_PARITY_EN
        test_parity();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d words required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
